// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the five-stage pipeline: load-use, memory wait, redirect flush, ebreak halt.
// Optional performance counters are enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl #(
   parameter int REG_ADDR_WIDTH = 5,
   parameter int FLUSH_CYCLES   = 2,
   parameter int CNT_WIDTH      = 32
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      id_valid,
   input  logic                      id_rs1_ren,
   input  logic                      id_rs2_ren,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
   input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
   input  logic                      ex_valid,
   input  logic                      ex_is_load,
   input  logic                      ex_reg_wen,
   input  logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
   input  logic                      ex_redirect,
   input  logic                      ex_ebreak,
   input  logic                      mem_req,
   input  logic                      mem_ack,
   output logic                      pc_stall,
   output logic                      if_id_stall,
   output logic                      if_id_flush,
   output logic                      id_ex_hold,
   output logic                      id_ex_bubble,
   output logic                      halted
`ifdef HAZARD_PERF_CNT_EN
   ,
   output logic [CNT_WIDTH-1:0]      perf_stall_cnt,
   output logic [CNT_WIDTH-1:0]      perf_flush_cnt
`endif
);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_MEM_WAIT,
      ST_FLUSH,
      ST_HALT
   } state_t;

   if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 15 || CNT_WIDTH < 1) begin : g_param_check
      $error("pipe_hazard_ctrl: illegal parameter value");
   end

   // The redirect cycle itself is the first bubble, so FLUSH covers the remaining FLUSH_CYCLES-1.
   localparam logic [3:0] FCNT_INIT = (FLUSH_CYCLES > 1) ? 4'(FLUSH_CYCLES - 2) : 4'd0;

   state_t     state;
   state_t     state_next;
   logic [3:0] fcnt;
   logic [3:0] fcnt_next;
   logic       stall;
   logic       redirect_accept;
   logic       mem_stall;
   logic       load_use;

   assign mem_stall = mem_req & ~mem_ack;

   assign load_use = id_valid & ex_valid & ex_is_load & ex_reg_wen
                   & (ex_rd_addr != '0)
                   & ((id_rs1_ren & (id_rs1_addr == ex_rd_addr))
                    | (id_rs2_ren & (id_rs2_addr == ex_rd_addr)));

   assign pc_stall    = stall;
   assign if_id_stall = stall;

   always_comb begin
      state_next      = state;
      fcnt_next       = fcnt;
      stall           = 1'b0;
      if_id_flush     = 1'b0;
      id_ex_hold      = 1'b0;
      id_ex_bubble    = 1'b0;
      redirect_accept = 1'b0;
      case (state)
         ST_RUN: begin
            if (mem_stall) begin
               stall      = 1'b1;
               id_ex_hold = 1'b1;
               state_next = ST_MEM_WAIT;
            end else if (ex_valid && ex_ebreak) begin
               stall        = 1'b1;
               id_ex_bubble = 1'b1;
               state_next   = ST_HALT;
            end else if (ex_redirect) begin
               if_id_flush     = 1'b1;
               id_ex_bubble    = 1'b1;
               redirect_accept = 1'b1;
               if (FLUSH_CYCLES > 1) begin
                  fcnt_next  = FCNT_INIT;
                  state_next = ST_FLUSH;
               end
            end else if (load_use) begin
               stall        = 1'b1;
               id_ex_bubble = 1'b1;
            end
         end
         ST_MEM_WAIT: begin
            if (mem_stall) begin
               stall      = 1'b1;
               id_ex_hold = 1'b1;
            end else begin
               state_next = ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (mem_stall) begin
               stall      = 1'b1;
               id_ex_hold = 1'b1;
            end else begin
               if_id_flush  = 1'b1;
               id_ex_bubble = 1'b1;
               if (fcnt == 4'd0) begin
                  state_next = ST_RUN;
               end else begin
                  fcnt_next = fcnt - 4'd1;
               end
            end
         end
         ST_HALT: begin
            stall        = 1'b1;
            id_ex_bubble = 1'b1;
         end
         default: begin
            state_next = ST_RUN;
         end
      endcase
   end

   // HALT is only left through reset, so halted simply tracks entry into it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= ST_RUN;
         fcnt   <= 4'd0;
         halted <= 1'b0;
      end else begin
         state  <= state_next;
         fcnt   <= fcnt_next;
         halted <= (state_next == ST_HALT);
      end
   end

`ifdef HAZARD_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (stall && (state != ST_HALT) && (perf_stall_cnt != '1)) begin
            perf_stall_cnt <= perf_stall_cnt + CNT_WIDTH'(1);
         end
         if (redirect_accept && (perf_flush_cnt != '1)) begin
            perf_flush_cnt <= perf_flush_cnt + CNT_WIDTH'(1);
         end
      end
   end
`endif

endmodule
